// File: rtl/sseg_mux_scan.sv
// Time-multiplexed seven-segment driver: one digit per refresh slot, hex decode,
// per-digit blank/blink, leading-zero suppression and 16-level PWM brightness.
// Latency: 1 cycle from state/inputs to registered outputs. No backpressure (free-running scan).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   digits            packed hex nibbles, digit i = digits[4i+3:4i], digit 0 least significant
//   dp_in/blank/blink per-digit decimal point request, force-dark, blink enable
//   lz_suppress       enable leading-zero suppression
//   brightness        0 = minimum duty, 15 = full duty
//   an                digit enables (polarity set by AN_ACTIVE_LOW)
//   sseg, dp          segments {g,f,e,d,c,b,a} and decimal point (polarity set by SEG_ACTIVE_LOW)
//   frame_start       one-cycle pulse as the scan of digit 0 begins
module sseg_mux_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_LOG2   = 16,
  parameter int GUARD          = 16,
  parameter int BLINK_LOG2     = 5,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

  // Scan state
  logic [REFRESH_LOG2-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_LOG2-1:0]   frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  // zero_from[i] = nibble i and every higher nibble are all zero
  logic [NUM_DIGITS-1:0]   zero_from;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Counter chain: slot -> digit index -> frame -> blink phase
  always_comb begin
    slot_cnt_d    = slot_cnt_q + 1'b1;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_cnt_q == '1) begin
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d       = '0;
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (frame_cnt_q == '1) begin
          blink_phase_d = ~blink_phase_q;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (digits[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (digits[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    int                    cur_i;
    logic [3:0]            nib;
    logic                  in_window;
    logic                  suppressed;
    logic                  on;
    logic [6:0]            seg_hi;
    logic [NUM_DIGITS-1:0] an_hi;

    cur_i = int'(idx_q);
    nib   = digits[4*cur_i +: 4];

    // The guard keeps the previous digit's anode off long enough to avoid ghosting;
    // the top 4 slot bits form the PWM ramp compared against brightness.
    in_window  = (slot_cnt_q >= REFRESH_LOG2'(GUARD)) &&
                 (slot_cnt_q[REFRESH_LOG2-1 -: 4] <= brightness);
    suppressed = lz_suppress && (cur_i != 0) && zero_from[cur_i];

    // A suppressed digit still lights its anode when it carries a decimal point,
    // but with the segments dark.
    on = in_window && !blank[cur_i] && !(blink[cur_i] && blink_phase_q) &&
         (!suppressed || dp_in[cur_i]);

    seg_hi = (on && !suppressed) ? hex_decode(nib) : 7'h00;

    an_hi = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_hi[i] = on && (idx_q == IDX_W'(i));
    end

    an_d          = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
    sseg_d        = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_d          = SEG_ACTIVE_LOW ? ~(dp_in[cur_i] && on) : (dp_in[cur_i] && on);
    frame_start_d = (idx_q == '0) && (slot_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= AN_OFF;
      sseg_q        <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_mux_scan.sv
// Testbench for sseg_mux_scan: cycle model of the scan driven from elapsed time since reset,
// with expected outputs queued per cycle and compared against an active-low and an
// active-high build of the driver.
module tb_sseg_mux_scan;

  localparam int N  = 4;
  localparam int R  = 6;
  localparam int G  = 2;
  localparam int BL = 1;
  localparam int SLOT  = 1 << R;
  localparam int FRAME = N * SLOT;

  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       fs;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits;
  logic [3:0]    dp_in, blank, blink, brightness;
  logic          lz;

  logic [3:0]    an_lo, an_hi;
  logic [6:0]    sseg_lo, sseg_hi;
  logic          dp_lo, dp_hi, fs_lo, fs_hi;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            t = 0;
  int            act_cnt[N];
  int            fs_cnt;

  always #5 clk = ~clk;

  sseg_mux_scan #(
    .NUM_DIGITS(N), .REFRESH_LOG2(R), .GUARD(G), .BLINK_LOG2(BL),
    .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank(blank),
    .blink(blink), .lz_suppress(lz), .brightness(brightness),
    .an(an_lo), .sseg(sseg_lo), .dp(dp_lo), .frame_start(fs_lo)
  );

  sseg_mux_scan #(
    .NUM_DIGITS(N), .REFRESH_LOG2(R), .GUARD(G), .BLINK_LOG2(BL),
    .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank(blank),
    .blink(blink), .lz_suppress(lz), .brightness(brightness),
    .an(an_hi), .sseg(sseg_hi), .dp(dp_hi), .frame_start(fs_hi)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, act, exp);
    end
  endtask

  // Expected active-low outputs for the edge that ends cycle tt after reset release.
  function automatic exp_t model(input int tt);
    exp_t       e;
    int         slot, idx, frame, phase;
    logic [3:0] nib;
    logic       supp, on;
    slot  = tt % SLOT;
    idx   = (tt / SLOT) % N;
    frame = tt / FRAME;
    phase = (frame >> BL) & 1;
    nib   = digits[4*idx +: 4];
    supp  = lz && (idx > 0) && ((digits >> (4*idx)) == 16'h0);
    on    = (slot >= G) && ((slot >> (R-4)) <= int'(brightness)) && !blank[idx] &&
            !(blink[idx] && (phase == 1)) && (!supp || dp_in[idx]);
    e.an   = on ? ~(4'b0001 << idx) : 4'hF;
    e.sseg = (on && !supp) ? ~DEC[nib] : 7'h7F;
    e.dp   = ~(dp_in[idx] && on);
    e.fs   = (tt % FRAME) == 0;
    return e;
  endfunction

  task automatic step();
    exp_t       e, g;
    logic [3:0] inv_an;
    logic [6:0] inv_sseg;
    logic       inv_dp;
    e = model(t);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      inv_an   = ~g.an;
      inv_sseg = ~g.sseg;
      inv_dp   = ~g.dp;
      chk("an",      an_lo,   g.an);
      chk("sseg",    sseg_lo, g.sseg);
      chk("dp",      dp_lo,   g.dp);
      chk("fs",      fs_lo,   g.fs);
      chk("an_hi",   an_hi,   inv_an);
      chk("sseg_hi", sseg_hi, inv_sseg);
      chk("dp_hi",   dp_hi,   inv_dp);
      chk("fs_hi",   fs_hi,   g.fs);
      chk("an_excl", ($countones(~an_lo) <= 1), 32'd1);
    end
    for (int i = 0; i < N; i++) begin
      if (an_lo[i] == 1'b0) act_cnt[i]++;
    end
    if (fs_lo) fs_cnt++;
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < N; i++) act_cnt[i] = 0;
    fs_cnt = 0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic chk_counts(input string tag, input int c0, input int c1,
                            input int c2, input int c3);
    int exp_c[N];
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_on%0d", tag, i), act_cnt[i], exp_c[i]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},    an_lo,   32'hF);
    chk({tag, "_sseg"},  sseg_lo, 32'h7F);
    chk({tag, "_dp"},    dp_lo,   32'd1);
    chk({tag, "_fs"},    fs_lo,   32'd0);
    chk({tag, "_anhi"},  an_hi,   32'h0);
    chk({tag, "_ssghi"}, sseg_hi, 32'h0);
    chk({tag, "_dphi"},  dp_hi,   32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    sb.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    digits     = 16'h3210;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    blink      = 4'b0000;
    brightness = 4'd15;
    lz         = 1'b0;

    #12;
    chk_reset("rst");
    @(posedge clk);
    #1;
    chk_reset("rst_hold");
    release_reset();

    // Full-brightness scan
    run(FRAME);
    chk_counts("scan", 62, 62, 62, 62);
    chk("scan_fs", fs_cnt, 32'd1);

    brightness = 4'd3;
    run(FRAME);
    chk_counts("br3", 14, 14, 14, 14);

    brightness = 4'd0;
    run(FRAME);
    chk_counts("br0", 2, 2, 2, 2);

    brightness = 4'd15;
    digits = 16'h0050;
    lz = 1'b1;
    run(FRAME);
    chk_counts("lz", 62, 62, 0, 0);

    dp_in = 4'b1000;
    run(FRAME);
    chk_counts("lzdp", 62, 62, 0, 62);

    digits = 16'h0000;
    dp_in = 4'b0000;
    run(FRAME);
    chk_counts("lz0", 62, 0, 0, 0);

    lz = 1'b0;
    digits = 16'h3210;
    blink = 4'b0010;
    run(4 * FRAME);
    chk_counts("blink", 248, 124, 248, 248);
    chk("blink_fs", fs_cnt, 32'd4);

    blink = 4'b0000;
    blank = 4'b0001;
    dp_in = 4'b0001;
    run(FRAME);
    chk_counts("blank", 0, 62, 62, 62);

    blank = 4'b0000;
    dp_in = 4'b0000;
    digits = 16'hFEDC;
    run(FRAME);
    chk_counts("hex_hi", 62, 62, 62, 62);

    digits = 16'hBA98;
    run(FRAME);
    chk_counts("hex_lo", 62, 62, 62, 62);

    // Reset asserted mid-slot takes effect without a clock edge
    digits = 16'h3210;
    run(100);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(posedge clk);
    #1;
    chk_reset("rst_mid_hold");
    release_reset();
    run(FRAME + 44);
    chk("restart_fs", fs_cnt, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
